// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit driving a word-only data memory (optional LSU_MISALIGN_TRAP_EN)
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_adr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  misaligned_err,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_WrEn
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [15:0] wdata_q;
  logic        mis_q;

  logic        acc_mis;
  logic [1:0]  acc_size;
  logic [1:0]  acc_lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Both gated by reset so a write in flight never reaches memory on the reset edge.
  assign req_ready      = (state == IDLE) && !reset;
  assign mem_WrEn       = (state == WR) && !reset;
  assign misaligned_err = mis_q;

  // Decode the incoming request: effective size, byte lane and alignment fault.
  always_comb begin
    acc_mis  = 1'b0;
    acc_size = req_size;
    acc_lane = req_adr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    acc_mis = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_adr[0]) ||
              (req_size == 2'b10 && req_adr[1:0] != 2'b00);
`else
    // Without trapping, force natural alignment and treat the reserved size as a word.
    if (req_size == 2'b11) acc_size = 2'b10;
    case (acc_size)
      2'b01:   acc_lane = {req_adr[1], 1'b0};
      2'b10:   acc_lane = 2'b00;
      default: acc_lane = req_adr[1:0];
    endcase
`endif
  end

  // Extract the addressed lane from memory data and build the load result and store merge.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Request FSM with registered response and memory-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mis_q     <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= 16'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q    <= acc_lane;
            size_q    <= acc_size;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata[15:0];
            rsp_rdata <= '0;
            mis_q     <= acc_mis;
            mem_adr   <= {req_adr[ADDR_WIDTH-1:2], 2'b00};
            if (acc_mis) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end else if (req_we && acc_size == 2'b10) begin
              mem_wdata <= req_wdata;
              state     <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            mem_wdata <= merged;
            state     <= WR;
          end else begin
            rsp_rdata <= load_ext;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        WR: begin
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl against a byte-level reference model
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned_err;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_WrEn;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  rb  [0:255];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_adr(req_adr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .misaligned_err(misaligned_err), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_WrEn(mem_WrEn)
  );

  assign mem_rdata = mem[mem_adr[7:2]];
  always @(posedge clk) if (mem_WrEn) mem[mem_adr[7:2]] <= mem_wdata;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic poke(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) rb[4*w+i] = v[8*i +: 8];
  endtask

  // Reference: expected result computed from byte-addressed memory and the access rules.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [7:0] adr, input logic [31:0] wdata,
                            output logic [31:0] e_rdata, output logic e_err,
                            output int e_lat, output int e_wr);
    int n;
    logic [7:0] a;
    logic [31:0] v;
    logic [1:0] sz;
    e_rdata = 32'h0; e_err = 1'b0; e_wr = 0; e_lat = 2;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd3 || (size == 2'd1 && adr[0]) || (size == 2'd2 && adr[1:0] != 2'd0)) begin
      e_err = 1'b1; e_lat = 1;
      return;
    end
    sz = size; a = adr;
`else
    sz = (size == 2'd3) ? 2'd2 : size;
    a = (sz == 2'd1) ? (adr & 8'hFE) : (sz == 2'd2) ? (adr & 8'hFC) : adr;
`endif
    n = 1 << sz;
    if (we) begin
      for (int i = 0; i < n; i++) rb[a+i] = wdata[8*i +: 8];
      e_wr = 1;
      e_lat = (n < 4) ? 3 : 2;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(rb[a+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      e_rdata = v;
    end
  endtask

  // Drives one request, waits for its response and records what the memory port did.
  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] adr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int wrc, output logic [31:0] wadr, output logic [31:0] wdat,
                       output logic tmo);
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_adr = adr; req_wdata = wdata;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    tmo = !req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wrc = 0; wadr = 32'h0; wdat = 32'h0;
    for (g = 0; g < 10; g++) begin
      @(negedge clk);
      lat++;
      if (mem_WrEn) begin wrc++; wadr = mem_adr; wdat = mem_wdata; end
      if (rsp_valid) break;
    end
    if (!rsp_valid) tmo = 1'b1;
    rdata = rsp_rdata;
    err = misaligned_err;
  endtask

  logic [31:0] rd, wa, wd, e_rd;
  logic er, e_er, to;
  int lt, wc, e_lt, e_wc;

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_adr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset got %b exp 0", req_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_cmp++; if ({rsp_valid, misaligned_err, mem_WrEn} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {rsp_valid, misaligned_err, mem_WrEn}); end
    n_cmp++; if ({rsp_rdata, mem_adr, mem_wdata} !== 96'h0) begin n_fail++; $display("FAIL reset_regs got %h exp 0", {rsp_rdata, mem_adr, mem_wdata}); end
  endtask

  task automatic test_load_ext();
    poke(4, 32'h8899AABB);
    ref_access(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, e_rd, e_er, e_lt, e_wc);
    drive(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lt, wc, wa, wd, to);
    n_cmp++; if (rd !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_signed rdata got %h exp ffffff88", rd); end
    n_cmp++; if (lt !== 2 || to) begin n_fail++; $display("FAIL lb_latency got %0d exp 2 (timeout %b)", lt, to); end
    n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL lb_no_write got %0d writes exp 0", wc); end
    drive(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lt, wc, wa, wd, to);
    n_cmp++; if (rd !== 32'h00008899) begin n_fail++; $display("FAIL lhu rdata got %h exp 00008899", rd); end
    drive(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, rd, er, lt, wc, wa, wd, to);
    n_cmp++; if (rd !== 32'hFFFFAABB) begin n_fail++; $display("FAIL lh_signed rdata got %h exp ffffaabb", rd); end
  endtask

  task automatic test_store_byte();
    ref_access(1'b1, 2'd0, 1'b0, 8'h11, 32'h12345655, e_rd, e_er, e_lt, e_wc);
    drive(1'b1, 2'd0, 1'b0, 32'h11, 32'h12345655, rd, er, lt, wc, wa, wd, to);
    n_cmp++; if (lt !== 3 || to) begin n_fail++; $display("FAIL sb_latency got %0d exp 3 (timeout %b)", lt, to); end
    n_cmp++; if (wc !== 1) begin n_fail++; $display("FAIL sb_write_cycles got %0d exp 1", wc); end
    n_cmp++; if (wa !== 32'h10 || wd !== 32'h889955BB) begin n_fail++; $display("FAIL sb_write got adr %h data %h exp 10 889955bb", wa, wd); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sb_rdata got %h exp 0", rd); end
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lt, wc, wa, wd, to);
    n_cmp++; if (rd !== 32'h889955BB) begin n_fail++; $display("FAIL sb_readback got %h exp 889955bb", rd); end
  endtask

  task automatic test_store_word();
    ref_access(1'b1, 2'd2, 1'b0, 8'h20, 32'hDEADBEEF, e_rd, e_er, e_lt, e_wc);
    drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, rd, er, lt, wc, wa, wd, to);
    n_cmp++; if (lt !== 2 || to) begin n_fail++; $display("FAIL sw_latency got %0d exp 2 (timeout %b)", lt, to); end
    n_cmp++; if (wc !== 1 || wa !== 32'h20 || wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_write got n %0d adr %h data %h exp 1 20 deadbeef", wc, wa, wd); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got %h exp 0", rd); end
  endtask

  task automatic test_misaligned();
    ref_access(1'b0, 2'd1, 1'b1, 8'h11, 32'h0, e_rd, e_er, e_lt, e_wc);
    drive(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, rd, er, lt, wc, wa, wd, to);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (er !== 1'b1 || lt !== 1 || to) begin n_fail++; $display("FAIL mis_trap got err %b lat %0d exp 1 1", er, lt); end
    n_cmp++; if (wc !== 0 || rd !== 32'h0) begin n_fail++; $display("FAIL mis_trap_side got writes %0d rdata %h exp 0 0", wc, rd); end
`else
    n_cmp++; if (er !== 1'b0 || lt !== 2 || to) begin n_fail++; $display("FAIL mis_align got err %b lat %0d exp 0 2", er, lt); end
    n_cmp++; if (rd !== 32'h000055BB) begin n_fail++; $display("FAIL mis_align_rdata got %h exp 000055bb", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lt, wc, wa, wd, to);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_done got %b exp 0", req_ready); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after got %b exp 1", req_ready); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rdata got %h exp deadbeef", rd); end
  endtask

  task automatic test_random();
    logic [31:0] r, w;
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      w = $urandom;
      ref_access(r[0], r[2:1], r[3], r[15:8], w, e_rd, e_er, e_lt, e_wc);
      drive(r[0], r[2:1], r[3], {24'h0, r[15:8]}, w, rd, er, lt, wc, wa, wd, to);
      n_cmp++; if (to || rd !== e_rd || er !== e_er || lt !== e_lt || wc !== e_wc) begin
        n_fail++;
        $display("FAIL rand[%0d] we %b sz %0d u %b adr %h: got rd %h err %b lat %0d wr %0d exp %h %b %0d %0d",
                 k, r[0], r[2:1], r[3], r[15:8], rd, er, lt, wc, e_rd, e_er, e_lt, e_wc);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    poke(8, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_adr = 32'h21; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_WrEn !== 1'b1) begin n_fail++; $display("FAIL rst_wr_reached got %b exp 1", mem_WrEn); end
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_WrEn !== 1'b0) begin n_fail++; $display("FAIL rst_wren_gated got %b exp 0", mem_WrEn); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || mem_WrEn) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_response got %0d events exp 0", seen); end
    n_cmp++; if (mem[8] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_mem_unchanged got %h exp cafef00d", mem[8]); end
  endtask

  task automatic test_memory_final();
    logic [31:0] v;
    for (int w = 0; w < 64; w++) begin
      v = {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
      n_cmp++; if (mem[w] !== v) begin n_fail++; $display("FAIL mem_word[%0d] got %h exp %h", w, mem[w], v); end
    end
  endtask

  initial begin
    for (int w = 0; w < 64; w++) poke(w, $urandom);
    test_reset();
    test_load_ext();
    test_store_byte();
    test_store_word();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_memory_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit on the CPU side of the data memory; it initiates all data-memory requests.
- Accepts byte, halfword and word loads and stores from the execute stage through a valid/ready handshake.
- Drives the word-only data memory port (address, write data, write enable) and returns sign- or zero-extended load data.
- The memory has no byte enables, so sub-word stores are done as read-modify-write.

Parameters:
- ADDR_WIDTH, 32, byte-address width of request and memory address.
- DATA_WIDTH, 32, data width. Only 32 is supported (four little-endian byte lanes).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_adr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-justified.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- misaligned_err  output  1  valid with rsp_valid; access rejected.
- mem_adr  output  ADDR_WIDTH  word-aligned address: {adr[ADDR_WIDTH-1:2],2'b00}.
- mem_wdata  output  DATA_WIDTH  write data to memory.
- mem_rdata  input  DATA_WIDTH  read data from memory.
- mem_WrEn  output  1  memory write enable.

Behaviour:
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, misaligned_err 0, mem_adr 0, mem_wdata 0, mem_WrEn 0.
- req_ready = (state==IDLE) && !reset.
- mem_WrEn = (state==WR) && !reset (combinational gate).
- Memory timing: address presented for one full cycle; mem_rdata is sampled at the rising edge ending that cycle.
- Request is accepted on the edge where req_valid && req_ready. That edge latches adr, size, we, unsigned, wdata.
- States: IDLE, RD, WR, DONE.
- IDLE -> RD: load, or store with size 00/01 (aligned).
- IDLE -> WR: word store (aligned).
- IDLE -> DONE: misaligned access; misaligned_err = 1, no memory access.
- RD -> DONE (load): captures the lane from mem_rdata and extends it into rsp_rdata.
- RD -> WR (sub-word store): captures mem_rdata and merges the store lane into it.
- WR -> DONE.
- DONE -> IDLE: rsp_valid = 1 for exactly this one cycle.
- Latency from accept edge to rsp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned: 1 cycle.
- Next request accepted at earliest in the cycle after DONE.
- Lane selection:
  - byte lane = adr[1:0], bits [8*lane+7 : 8*lane];
  - half lane = adr[1], bits [16*adr[1]+15 : 16*adr[1]].
- Merge: unselected bytes of mem_wdata equal captured mem_rdata; selected bytes come from req_wdata[7:0] or [15:0].
- Alignment rules:
  - half requires adr[0] == 0;
  - word requires adr[1:0] == 0;
  - size 11 is always misaligned_err.
- rsp_rdata and misaligned_err hold their values outside DONE. They are cleared on the next accept.
- mem_adr holds the latched address until the next accept.
- Reset mid-operation: returns to IDLE at that edge with no response. A WR in progress is suppressed by the mem_WrEn gate, so memory is unchanged.
- req_valid while not ready: ignored. The requester must hold the request until accepted.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests behave as above (misaligned_err, no memory access).
- Undefined:
  - misaligned_err is tied 0;
  - misaligned addresses are forced to natural alignment (half: adr[0] treated as 0; word: adr[1:0] treated as 0) and the access proceeds normally;
  - size 11 is treated as word.

Test Plan:
- Memory word 0x10 = 0x8899AABB. Load byte signed, adr 0x13 -> rsp_valid 2 cycles after accept, rsp_rdata 0xFFFFFF88, mem_WrEn never high.
- Load half unsigned, adr 0x12 -> rsp_rdata 0x00008899. Load half signed, adr 0x10 -> 0xFFFFAABB.
- Store byte, req_wdata 0x12345655, adr 0x11 -> RD cycle, then WR with mem_adr 0x10, mem_wdata 0x889955BB, mem_WrEn high exactly 1 cycle, rsp_valid 3 cycles after accept. Word load at 0x10 then returns 0x889955BB.
- Word store 0xDEADBEEF at 0x20 -> no RD; WR in cycle after accept, rsp_valid next cycle, rsp_rdata 0.
- Half load at 0x11:
  - with LSU_MISALIGN_TRAP_EN -> misaligned_err=1 and rsp_valid 1 cycle after accept, no memory access;
  - without it -> reads half at 0x10.
- Reset asserted during WR of a byte store -> mem_WrEn stays 0, memory unchanged, no rsp_valid; req_ready=1 in the first cycle after reset deasserts.
